// File: rtl/ptr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ptr_pkg
//  Purpose  : Shared constants for the PDP-6 paper-tape reader (device 104).
//             Status-word bit positions are given in PDP-6 numbering
//             (bit 0 = MSB of the 36-bit word); vbit() maps them to the
//             Verilog [35:0] index.
//  Revision : 1.0 - initial release
// ============================================================================
package ptr_pkg;

    localparam logic [6:0] PTR_DEVCODE     = 7'o104;

    localparam int         WORD_W          = 36;
    localparam int         FRAME_W         = 8;
    localparam int         FRAMES_PER_WORD = 6;
    localparam int         BITS_PER_FRAME  = 6;

    // Status bit indices, PDP-6 numbering
    localparam int         ST_EOT          = 29;
    localparam int         ST_BINARY       = 30;
    localparam int         ST_BUSY         = 31;
    localparam int         ST_FLAG         = 32;
    localparam int         ST_PIA_LSB      = 35;
    localparam int         PIA_W           = 3;

    // PDP-6 bit number -> Verilog bit index within a 36-bit word
    function automatic int vbit(input int pdp_bit);
        return WORD_W - 1 - pdp_bit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ptr_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : ptr_assembler
//  Purpose  : Packs accepted tape frames into a 36-bit word.
//             Binary mode: frames without hole 8 are discarded, frames with
//             hole 8 contribute their low six bits; six of them make a word.
//             Alpha mode: each frame is a complete word (right-justified).
//  Ports    : clk, reset (sync, active-low)
//             clear     - drop the partial word (buffer and frame count)
//             accept    - a frame is being consumed this cycle
//             binary    - packing mode
//             data[7:0] - frame, bit 7 = hole 8
//             word[35:0]- assembly buffer
//             word_done - combinational: this accept completes a word
//  Revision : 1.0 - initial release
// ============================================================================
module ptr_assembler
    import ptr_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               accept,
    input  logic               binary,
    input  logic [FRAME_W-1:0] data,
    output logic [WORD_W-1:0]  word,
    output logic               word_done
);

    logic [2:0] r_count;
    logic       w_hole8;
    logic       w_last;

    assign w_hole8   = data[FRAME_W-1];
    assign w_last    = (r_count == 3'(FRAMES_PER_WORD - 1));
    assign word_done = accept && (!binary || (w_hole8 && w_last));

    always_ff @(posedge clk) begin
        if (!reset) begin
            word    <= '0;
            r_count <= '0;
        end else if (clear) begin
            word    <= '0;
            r_count <= '0;
        end else if (accept) begin
            if (!binary) begin
                word    <= {{(WORD_W - FRAME_W){1'b0}}, data};
                r_count <= '0;
            end else if (w_hole8) begin
                word    <= {word[WORD_W-BITS_PER_FRAME-1:0], data[BITS_PER_FRAME-1:0]};
                r_count <= w_last ? 3'd0 : r_count + 3'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ptr_reader.sv
`default_nettype none
// ============================================================================
//  Module   : ptr_reader
//  Purpose  : PDP-6 paper-tape reader on the IO bus. Pulls frames from a
//             tape-stream source, assembles words, raises flag / PI request.
//             The busy/flag pair is the state: IDLE (0/0), READING (busy),
//             DONE (flag).
//  Options  : PTR_EOT_EN - adds end-of-tape detection (status bit 29) after
//             EOT_CYCLES idle cycles while busy.
//  Ports    : clk, reset (sync, active-low)
//             iobus_ios[6:0]        - device select
//             iobus_cono_clear/set  - CONO pulses (set loads bits 30-35)
//             iobus_datai           - buffer read pulse
//             iobus_status          - CONI level
//             iobus_rdi_start       - read-in start (not gated by select)
//             iobus_iob_in[35:0]    - CPU data in
//             iobus_iob_out[35:0]   - device data out, 0 when not selected
//             iobus_pi_req[7:1]     - one-hot PI request (registered)
//             tape_valid/data/ready - frame stream handshake
//  Revision : 1.0 - initial release
// ============================================================================
module ptr_reader
    import ptr_pkg::*;
#(
    parameter logic [6:0] DEVCODE      = PTR_DEVCODE,
    parameter int         FRAME_CYCLES = 16,
    parameter int         EOT_CYCLES   = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         iobus_ios,
    input  logic               iobus_cono_clear,
    input  logic               iobus_cono_set,
    input  logic               iobus_datai,
    input  logic               iobus_status,
    input  logic               iobus_rdi_start,
    input  logic [WORD_W-1:0]  iobus_iob_in,
    output logic [WORD_W-1:0]  iobus_iob_out,
    output logic [7:1]         iobus_pi_req,
    input  logic               tape_valid,
    input  logic [FRAME_W-1:0] tape_data,
    output logic               tape_ready
);

    localparam int PACE_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int B_EOT  = vbit(ST_EOT);
    localparam int B_BIN  = vbit(ST_BINARY);
    localparam int B_BUSY = vbit(ST_BUSY);
    localparam int B_FLAG = vbit(ST_FLAG);
    localparam int B_PIA  = vbit(ST_PIA_LSB);

    logic              r_binary;
    logic              r_busy;
    logic              r_flag;
    logic [PIA_W-1:0]  r_pia;
    logic [PACE_W-1:0] r_pace;
    logic              r_eot;

    logic              w_sel;
    logic              w_datai;
    logic              w_clr;
    logic              w_set;
    logic              w_accept;
    logic              w_asm_clear;
    logic              w_word_done;
    logic              w_eot_fire;
    logic [WORD_W-1:0] w_buffer;
    logic [WORD_W-1:0] w_status;
    logic [7:1]        w_pi_next;
    logic              unused_iob;

    assign w_sel   = (iobus_ios == DEVCODE);
    assign w_datai = w_sel && iobus_datai;
    assign w_clr   = w_sel && iobus_cono_clear;
    assign w_set   = w_sel && iobus_cono_set;

    // DATAI wins over a coincident frame: the frame stays on offer.
    assign tape_ready = r_busy && (r_pace == '0) && !w_datai;
    assign w_accept   = tape_valid && tape_ready;

    // The partial word is discarded whenever a new read begins.
    assign w_asm_clear = w_datai || iobus_rdi_start ||
                         (w_set && iobus_iob_in[B_BUSY]);

    assign unused_iob = ^{iobus_iob_in[WORD_W-1:B_BIN+1]};

    ptr_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_asm_clear),
        .accept    (w_accept),
        .binary    (r_binary),
        .data      (tape_data),
        .word      (w_buffer),
        .word_done (w_word_done)
    );

`ifdef PTR_EOT_EN
    localparam int IDLE_W = $clog2(EOT_CYCLES + 1);
    logic [IDLE_W-1:0] r_idle;

    // Fires on the EOT_CYCLES-th consecutive busy cycle with no frame offered.
    assign w_eot_fire = r_busy && !tape_valid && (r_idle == IDLE_W'(EOT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idle <= '0;
        end else if (!r_busy || tape_valid || w_eot_fire) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + IDLE_W'(1);
        end
    end
`else
    logic [31:0] unused_eot_cycles;
    assign unused_eot_cycles = EOT_CYCLES;
    assign w_eot_fire        = 1'b0;
`endif

    always_comb begin
        w_status                    = '0;
        w_status[B_BIN]             = r_binary;
        w_status[B_BUSY]            = r_busy;
        w_status[B_FLAG]            = r_flag;
        w_status[B_PIA +: PIA_W]    = r_pia;
        w_status[B_EOT]             = r_eot;
    end

    always_comb begin
        iobus_iob_out = '0;
        if (w_datai) begin
            iobus_iob_out = w_buffer;
        end else if (w_sel && iobus_status) begin
            iobus_iob_out = w_status;
        end
    end

    always_comb begin
        w_pi_next = '0;
        if (r_flag && (r_pia != '0)) begin
            w_pi_next[r_pia] = 1'b1;
        end
    end

    // Later statements take priority: frame result, EOT, DATAI, CONO clear,
    // CONO set, read-in start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_binary     <= 1'b0;
            r_busy       <= 1'b0;
            r_flag       <= 1'b0;
            r_pia        <= '0;
            r_pace       <= '0;
            r_eot        <= 1'b0;
            iobus_pi_req <= '0;
        end else begin
            if (w_accept) begin
                r_pace <= PACE_W'(FRAME_CYCLES - 1);
            end else if (r_pace != '0) begin
                r_pace <= r_pace - PACE_W'(1);
            end

            if (w_word_done) begin
                r_flag <= 1'b1;
                r_busy <= 1'b0;
            end
            if (w_eot_fire) begin
                r_eot  <= 1'b1;
                r_flag <= 1'b1;
                r_busy <= 1'b0;
            end
            if (w_datai) begin
                r_flag <= 1'b0;
                r_busy <= 1'b1;
                r_eot  <= 1'b0;
            end
            if (w_clr) begin
                r_binary <= 1'b0;
                r_busy   <= 1'b0;
                r_flag   <= 1'b0;
                r_pia    <= '0;
                r_eot    <= 1'b0;
            end
            if (w_set) begin
                r_binary <= iobus_iob_in[B_BIN];
                r_busy   <= iobus_iob_in[B_BUSY];
                r_flag   <= iobus_iob_in[B_FLAG];
                r_pia    <= iobus_iob_in[B_PIA +: PIA_W];
            end
            if (iobus_rdi_start) begin
                r_binary <= 1'b1;
                r_busy   <= 1'b1;
                r_flag   <= 1'b0;
                r_eot    <= 1'b0;
            end

            iobus_pi_req <= w_pi_next;
        end
    end

`ifndef PTR_EOT_EN
    // Without the option, eot is a constant-zero register.
`endif

endmodule
`default_nettype wire

// File: doc/ptr_reader.md
Name: ptr_reader

Overview:
- Paper-tape reader peripheral on the PDP-6 IO bus, device code 104.
- It is the sending end of the CPU's DATAI/read-in path. It pulls 8-hole frames from a tape-stream source and assembles them into words.
- In binary mode it packs six 6-bit frames into one 36-bit word. In alpha mode it delivers one 8-bit frame per word.
- It raises a flag and a PI request when a word is ready. It sits beside mem0/fmem0 under pdp6 and is driven by `key_read_in`.

Parameters:
- DEVCODE, 7'o104: IO-bus device select (`iobus_ios` match).
- FRAME_CYCLES, 16: minimum clk cycles between accepted frames (reader speed model; must be ≥1).
- EOT_CYCLES, 256: idle cycles while busy before end-of-tape is declared (optional feature only).

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-low reset.
- `iobus_ios`, in, 7: device select code from the CPU.
- `iobus_cono_clear`, in, 1: one-cycle pulse; clears CONO-writable state.
- `iobus_cono_set`, in, 1: one-cycle pulse; loads status from `iobus_iob_in`.
- `iobus_datai`, in, 1: one-cycle pulse; CPU reads the buffer.
- `iobus_status`, in, 1: level; CPU reads CONI status.
- `iobus_rdi_start`, in, 1: one-cycle pulse from read-in; forces binary read start.
- `iobus_iob_in`, in, 36: CPU-to-device data, bit 0 = MSB.
- `iobus_iob_out`, out, 36: device-to-CPU data; zero when not selected.
- `iobus_pi_req`, out, 7: one-hot PI request, bit 1..7 per PIA.
- `tape_valid`, in, 1: source has a frame available.
- `tape_data`, in, 8: frame; bit 7 = hole 8 (binary marker).
- `tape_ready`, out, 1: accept strobe; frame consumed when `tape_valid && tape_ready`.

Behaviour:
- sel = (`iobus_ios` == DEVCODE). Bus pulses are ignored unless sel, except `iobus_rdi_start`.
- Reset (reset==0 at clk edge):
  - buffer=0, binary=0, busy=0, flag=0, pia=0, frame count=0, pacing counter=0.
  - Outputs: `iobus_iob_out`=0, `iobus_pi_req`=0, `tape_ready`=0.
  - Reset mid-word discards the partial word.
- Status word, bits MSB-first: 30=binary, 31=busy, 32=flag, 33-35=pia. All other bits 0.
- `iobus_status`&&sel: `iobus_iob_out`=status (combinational).
- `iobus_datai`&&sel: `iobus_iob_out`=buffer (combinational). On that edge: flag←0, busy←1, frame count←0, buffer←0.
- `iobus_cono_clear`&&sel: binary, busy, flag, pia ←0.
- `iobus_cono_set`&&sel: status bits 30-35 ←`iob_in` bits 30-35. If busy becomes 1, buffer and frame count clear.
  - clear and set in the same cycle: clear first, then set.
- `iobus_rdi_start`: binary←1, busy←1, flag←0, buffer←0, frame count←0.
- States, encoded by busy and flag:
  - IDLE: busy=0, flag=0.
  - READING: busy=1.
  - DONE: flag=1, busy=0.
- READING:
  - Pacing counter counts down from FRAME_CYCLES-1 after each accepted frame.
  - `tape_ready`=1 only when busy && pacing counter==0.
  - Binary mode: frames with hole 8 clear are consumed and discarded.
  - Binary mode, hole 8 set: buffer←{buffer[6:35], data[5:0]} and frame count increments. When the 6th frame is accepted: flag←1, busy←0, count←0.
  - Alpha mode: buffer←{28'b0, data}; flag←1, busy←0.
- DATAI coinciding with a frame accept: DATAI wins, the frame is dropped (not consumed, `tape_ready` forced 0 that cycle).
- `iobus_pi_req`:
  - = (flag && pia≠0) ? 1<<(pia-1) as 7-bit field, bit index pia.
  - Registered, so one cycle latency after flag/pia change.
- A frame accepted to a full word → flag visible one cycle later.

Optional Feature:
- Macro PTR_EOT_EN.
- Defined:
  - Adds status bit 29 = eot.
  - While busy and `tape_valid`=0 for EOT_CYCLES consecutive cycles: eot←1, flag←1, busy←0, partial word kept in buffer.
  - eot clears on DATAI, CONO clear, rdi_start, reset.
- Undefined:
  - Reader waits indefinitely.
  - Bit 29 reads 0; no idle counter synthesized.

Decomposition:
- Package ptr_pkg: DEVCODE default, status bit indices (BINARY=30, BUSY=31, FLAG=32, PIA_LSB=35, EOT=29), word width 36, frame width 8.
- One sub-module ptr_assembler: 6-frame shift/count, hole-8 filter, word-complete pulse. Top keeps bus decode, status, pacing, PI.

Test Plan:
- Reset low 2 cycles while busy with 3 frames in → status reads 0, `pi_req`=0, `tape_ready`=0; next word starts from frame 0.
- rdi_start, tape frames 0o250,0o245,0o012(skipped),0o254,0o254,0o257,0o200 → DATAI returns 36'o504554545700, flag set exactly after 6th binary frame, binary=1.
- CONO set `iob_in`=0o000005 (pia=5, alpha), then busy via CONO 0o000025, frame 0o101 → buffer 36'o000000000101, `pi_req`=7'b0010000 one cycle after flag.
- DATAI in same cycle as a frame offer → offered frame not consumed, flag 0, busy 1; frame accepted FRAME_CYCLES later is honoured.
- CONO clear and set same cycle with `iob_in`=0o000003 → status reads 0o000003; unselected `ios`=0o070 pulses → no state change, `iob_out`=0.
- PTR_EOT_EN: busy, `tape_valid` held 0 for 256 cycles after 2 frames → eot=1, flag=1, buffer holds 12 bits; without macro busy stays 1.
